// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetched {instr, pc} entries with synchronous flush.
// When empty, the read port keeps presenting the last head value.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       wdata,
  output fetch_entry_t       rdata,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
);

  fetch_entry_t     r_mem [DEPTH];
  fetch_entry_t     r_last;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign count  = r_count;
  assign w_push = push & ~flush;
  assign w_pop  = pop & ~flush & ~empty;
  assign rdata  = empty ? r_last : r_mem[r_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_last  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (!empty) r_last <= r_mem[r_rd];
      if (flush) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr] <= wdata;
          r_wr        <= r_wr + AW'(1);
        end
        if (w_pop) r_rd <= r_rd + AW'(1);
        if (w_push && !w_pop)      r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem addressing, redirect handling and decode-side FIFO.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_flushed counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus8
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW         = AW + 1;
  localparam logic [31:0] PC_LIMIT   = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] RESET_PC_W = (RESET_PC & ~32'd3) % PC_LIMIT;

  logic [31:0]   r_pc;
  logic          r_has_head;
  logic [31:0]   w_pc_inc;
  logic [31:0]   w_pc_seq;
  logic [31:0]   w_target;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_head;

  // r_pc is always kept below PC_LIMIT, so one step can only reach the limit exactly.
  assign w_pc_inc = r_pc + PC_STEP;
  assign w_pc_seq = (w_pc_inc >= PC_LIMIT) ? '0 : w_pc_inc;
  assign w_target = (redirect_target & ~32'd3) % PC_LIMIT;

  assign imem_addr     = r_pc;
  assign if_valid      = (w_count != '0);
  assign w_pop         = if_valid & if_ready;
  assign w_push        = fetch_en & ~redirect_valid & (~w_full | w_pop);
  assign w_wdata.instr = imem_rd;
  assign w_wdata.pc    = r_pc;

  assign if_instr    = w_head.instr;
  assign if_pc       = w_head.pc;
  assign if_pc_plus8 = (r_has_head | if_valid) ? (w_head.pc + PC_READ_OFFSET) : '0;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_wdata),
    .rdata (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC_W;
      r_has_head <= 1'b0;
    end else begin
      r_has_head <= r_has_head | ~w_empty;
      if (redirect_valid)  r_pc <= w_target;
      else if (w_push)     r_pc <= w_pc_seq;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;

  // A squashed pop counts on top of the queued entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_push) r_perf_fetched <= sat_add32(r_perf_fetched, 32'd1);
      if (redirect_valid)
        r_perf_flushed <= sat_add32(r_perf_flushed, 32'(w_count) + 32'(w_pop));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue-based scoreboard of expected FIFO heads.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned IMEM_WORDS = 64;
  localparam logic [31:0] LIMIT      = 32'd256;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus8;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  logic [31:0] rom [IMEM_WORDS];

  always #5 clk = ~clk;
  assign imem_rd = rom[imem_addr[7:2]];

  fetch_stage #(
    .DEPTH      (DEPTH),
    .IMEM_WORDS (IMEM_WORDS),
    .RESET_PC   (32'd0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .imem_addr       (imem_addr),
    .imem_rd         (imem_rd),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus8     (if_pc_plus8)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_flushed    (perf_flushed)
`endif
  );

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t m_last;
  logic         m_seen;
  logic [31:0]  m_pc;
  logic [31:0]  m_fetched;
  logic [31:0]  m_flushed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("if_instr", if_instr, exp_q[0].instr);
      chk("if_pc", if_pc, exp_q[0].pc);
      chk("if_pc_plus8", if_pc_plus8, exp_q[0].pc + 32'd8);
      m_last = exp_q[0];
      m_seen = 1'b1;
    end else begin
      chk("hold_instr", if_instr, m_last.instr);
      chk("hold_pc", if_pc, m_last.pc);
      chk("hold_pc_plus8", if_pc_plus8, m_seen ? m_last.pc + 32'd8 : 32'd0);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_flushed", perf_flushed, m_flushed);
`endif
  endtask

  // Predict the effect of the upcoming clock edge from the inputs now applied.
  task automatic step();
    logic         pop;
    logic         push;
    fetch_entry_t e;
    pop  = (exp_q.size() != 0) && if_ready;
    push = fetch_en && !redirect_valid && ((exp_q.size() < DEPTH) || pop);
    if (redirect_valid) begin
      m_flushed = m_flushed + 32'(exp_q.size()) + 32'(pop);
      exp_q.delete();
      m_pc = (redirect_target & ~32'd3) % LIMIT;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        e.instr = rom[m_pc[7:2]];
        e.pc    = m_pc;
        exp_q.push_back(e);
        m_pc      = (m_pc + 32'd4) % LIMIT;
        m_fetched = m_fetched + 32'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc_plus8", if_pc_plus8, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    exp_q.delete();
    m_pc      = 32'd0;
    m_last    = '0;
    m_seen    = 1'b0;
    m_fetched = 32'd0;
    m_flushed = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    for (int unsigned i = 0; i < IMEM_WORDS; i++) rom[i] = 32'hA5000000 ^ (i * 32'h00013579);
    rom[0] = 32'hE3A0204B;
    reset = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    if_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // First fetch appears one cycle after enable.
    fetch_en = 1'b1;
    if_ready = 1'b1;
    step();
    chk("t1_instr", if_instr, 32'hE3A0204B);
    chk("t1_pc", if_pc, 32'd0);
    chk("t1_pc_plus8", if_pc_plus8, 32'd8);
    chk("t1_addr", imem_addr, 32'd4);
    repeat (6) step();

    // Stall: FIFO fills to DEPTH, PC stops at 8; then in-order drain.
    @(negedge clk);
    do_reset();
    if_ready = 1'b0;
    repeat (5) step();
    chk("t2_addr", imem_addr, 32'd8);
    chk("t2_head_pc", if_pc, 32'd0);
    if_ready = 1'b1;
    fetch_en = 1'b0;
    repeat (4) step();

    // Redirect while full with a squashed pop.
    fetch_en = 1'b1;
    if_ready = 1'b0;
    repeat (3) step();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000004A;
    step();
    redirect_valid = 1'b0;
    chk("t3_valid", 32'(if_valid), 32'd0);
    chk("t3_addr", imem_addr, 32'h48);
    step();
    chk("t3_pc", if_pc, 32'h48);

    // Out-of-range target reduces modulo memory size.
    redirect_valid = 1'b1;
    redirect_target = 32'h00000306;
    step();
    redirect_valid = 1'b0;
    chk("t3_tgt_mod", imem_addr, 32'h4);

    // PC wrap at the top of memory.
    redirect_valid = 1'b1;
    redirect_target = 32'hF8;
    step();
    redirect_valid = 1'b0;
    step();
    chk("t4_addr_fc", imem_addr, 32'hFC);
    step();
    chk("t4_addr_wrap", imem_addr, 32'h0);
    repeat (3) step();

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      fetch_en        = ($urandom_range(0, 3) != 0);
      if_ready        = ($urandom_range(0, 2) != 0);
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
      step();
    end
    redirect_valid = 1'b0;

    // Asynchronous reset with two entries queued.
    fetch_en = 1'b1;
    if_ready = 1'b0;
    repeat (3) step();
    chk("t5_full", 32'(if_valid), 32'd1);
    #2;
    do_reset();
    step();

`ifdef FETCH_PERF_EN
    @(negedge clk);
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    repeat (9) step();
    if_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("t6_fetched", perf_fetched, 32'd10);
    chk("t6_flushed", perf_flushed, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
